bcd2bin: RTL and testbench

Sequential binary-coded-decimal to binary converter implementing reverse double dabble: one right shift plus per-digit correction per clock. It is the inverse of the team's combinational binary-to-BCD converter. It sits behind UART/SPI command parsers, turning operator-entered decimal digits into binary register values. A valid/ready handshake on both sides lets it stall against slow producers and consumers.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd2bin_if.sv | 28 ++
 rtl/bcd_nibble_adj.sv | 9 +
 rtl/bcd2bin.sv | 111 +++++++++++
 tb/tb_bcd2bin.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD helpers: width derivation for BCD buses and the bcd2bin FSM state type.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } b2b_state_t;

  // BCD bits needed to hold any WIDTH-bit binary value (top digit may be partial).
  function automatic int unsigned bcd_width(input int unsigned width);
    return width + (width - 4) / 3 + 1;
  endfunction

  function automatic int unsigned bcd_digits(input int unsigned bcd_w);
    return (bcd_w + 3) / 4;
  endfunction

endpackage

// File: rtl/bcd2bin_if.sv
// Request/response handshake bundle for the BCD to binary converter.
interface bcd2bin_if
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned BCD_W = bcd_width(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [BCD_W-1:0] in_bcd;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_bin;
  logic             out_ovf;
  logic             out_err;

  modport master (
    output in_valid, in_bcd, out_ready,
    input  in_ready, out_valid, out_bin, out_ovf, out_err
  );

  modport slave (
    input  in_valid, in_bcd, out_ready,
    output in_ready, out_valid, out_bin, out_ovf, out_err
  );

endinterface

// File: rtl/bcd_nibble_adj.sv
// Per-digit correction for reverse double dabble: a nibble >= 8 after the shift loses 3.
module bcd_nibble_adj (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = (i_nib >= 4'd8) ? (i_nib - 4'd3) : i_nib;

endmodule

// File: rtl/bcd2bin.sv
// Sequential BCD to binary converter: one right shift plus digit correction per clock.
module bcd2bin
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  bcd2bin_if.slave  bus
);

  localparam int unsigned BCD_W = bcd_width(WIDTH);
  localparam int unsigned ND    = bcd_digits(BCD_W);
  localparam int unsigned BR_W  = 4 * ND;
  localparam int unsigned CNT_W = $clog2(BCD_W);

  b2b_state_t       r_state;
  logic [BR_W-1:0]  r_bcd;
  logic [BCD_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_bin;
  logic             r_out_ovf;
  logic             r_out_err;

  logic [BR_W-1:0]  w_bcd_load;
  logic             w_load_err;
  logic [BR_W-1:0]  w_bcd_shr;
  logic [BR_W-1:0]  w_bcd_adj;
  logic [BCD_W-1:0] w_acc_next;
  logic             w_accept;

  assign w_bcd_load = BR_W'(bus.in_bcd);
  assign w_bcd_shr  = r_bcd >> 1;
  assign w_acc_next = {r_bcd[0], r_acc[BCD_W-1:1]};
  assign w_accept   = bus.in_valid && bus.in_ready;

  // Any digit above 9 marks the request as malformed; it still runs to completion.
  always_comb begin
    w_load_err = 1'b0;
    for (int i = 0; i < int'(ND); i++) begin
      if (w_bcd_load[4*i +: 4] > 4'd9) begin
        w_load_err = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < int'(ND); g++) begin : g_adj
    bcd_nibble_adj u_adj (
      .i_nib (w_bcd_shr[4*g +: 4]),
      .o_nib (w_bcd_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bcd       <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_bin   <= '0;
      r_out_ovf   <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_bcd   <= w_bcd_load;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_err   <= w_load_err;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd <= w_bcd_adj;
          r_acc <= w_acc_next;
          if (r_cnt == CNT_W'(BCD_W - 1)) begin
            r_out_bin   <= w_acc_next[WIDTH-1:0];
            r_out_ovf   <= |w_acc_next[BCD_W-1:WIDTH];
            r_out_err   <= r_err;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE) && !rst;
  assign bus.out_valid = r_out_valid;
  assign bus.out_bin   = r_out_bin;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.out_err   = r_out_err;

endmodule

// File: tb/tb_bcd2bin.sv
// Directed self-checking bench for bcd2bin: conversions, flags, backpressure, reset abort.
module tb_bcd2bin;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bcd2bin_if #(.WIDTH(16)) bus ();

  bcd2bin #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, verify latency/result, hold DONE for 'hold' cycles, then release.
  task automatic run_conv(input logic [20:0] bcd, input logic [15:0] e_bin, input logic e_ovf,
                          input logic e_err, input int hold, input bit chk_lat);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    @(negedge clk);
    check_eq("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.out_ready = (hold == 0);
    bus.in_valid  = 1'b1;
    bus.in_bcd    = bcd;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_bcd   = 21'h1FFFFF;
    check_eq("in_ready_busy", 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("out_valid_timeout", 32'(seen), 32'd1);
    if (!seen) return;
    if (chk_lat) check_eq("latency", 32'(lat), 32'd21);
    if (!e_err) begin
      check_eq("out_bin", 32'(bus.out_bin), 32'(e_bin));
      check_eq("out_ovf", 32'(bus.out_ovf), 32'(e_ovf));
    end
    check_eq("out_err", 32'(bus.out_err), 32'(e_err));
    for (int k = 0; k < hold; k++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_bcd   = 21'h000099;
      @(negedge clk);
      check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
      check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
      if (!e_err) check_eq("hold_bin", 32'(bus.out_bin), 32'(e_bin));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("release_valid", 32'(bus.out_valid), 32'd0);
    check_eq("release_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d[6];
    int val;
    logic [20:0] bcd;
    bit seen_valid;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_bcd    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_bin", 32'(bus.out_bin), 32'd0);
    check_eq("rst_flags", {30'd0, bus.out_ovf, bus.out_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    run_conv(21'h065535, 16'hFFFF, 1'b0, 1'b0, 0, 1'b1);
    run_conv(21'h065536, 16'h0000, 1'b1, 1'b0, 0, 1'b1);
    run_conv(21'h100000, 16'h86A0, 1'b1, 1'b0, 0, 1'b1);
    run_conv(21'h000000, 16'h0000, 1'b0, 1'b0, 0, 1'b1);
    run_conv(21'h01A009, 16'h0000, 1'b0, 1'b1, 0, 1'b1);
    run_conv(21'h000009, 16'h0009, 1'b0, 1'b0, 0, 1'b1);
    run_conv(21'h199999, 16'h0D3F, 1'b1, 1'b0, 0, 1'b1);
    run_conv(21'h001234, 16'h04D2, 1'b0, 1'b0, 10, 1'b1);

    // Abort a conversion after six shifts; the seventh shift edge sees reset.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bcd   = 21'h001234;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("abort_out_bin", 32'(bus.out_bin), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_idle", 32'(bus.in_ready), 32'd1);
    seen_valid = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid = 1'b1;
    end
    check_eq("abort_no_result", 32'(seen_valid), 32'd0);
    run_conv(21'h000042, 16'h002A, 1'b0, 1'b0, 0, 1'b1);

    // Random legal values with idle gaps and random consumer stalls.
    for (int v = 0; v < 30; v++) begin
      for (int i = 0; i < 5; i++) d[i] = int'($urandom_range(0, 9));
      d[5] = int'($urandom_range(0, 1));
      val = d[5] * 100000 + d[4] * 10000 + d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0];
      bcd = {1'(d[5]), 4'(d[4]), 4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])};
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_conv(bcd, 16'(val), (val >= 65536), 1'b0, int'($urandom_range(0, 4)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
